flag_cond_unit: RTL and testbench
=================================

Name: flag_cond_unit

Overview:
- Consumer end of the arithmetic unit's result/flag interface.
- Captures Z/V/N from each flag-writing ALU op into the architectural flag register.
- Tracks in-flight flag writers between decode and execute.
- Resolves conditional branches through a valid/ready handshake, with same-cycle bypass from the executing ALU op. Sits between the decode/branch logic and the EX stage.

Parameters:
- DEPTH, 3, maximum number of flag-writing instructions in flight between issue and execute.
- CNT_W, 2, width of the pending counter; must satisfy 2**CNT_W > DEPTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- issue_fw  in  1  a flag-writing instruction leaves decode this cycle
- flag_wr_en  in  1  EX-stage op writes flags this cycle
- flag_mask  in  3  {Z,V,N} write enables for this op (ADD/SUB: 111; PADDSB/AND/NOR/shifts: 100)
- alu_result  in  16  EX-stage result
- alu_v  in  1  EX-stage overflow flag
- alu_n  in  1  EX-stage negative flag
- flush  in  1  pipeline squash this cycle
- flush_fw_cnt  in  CNT_W  number of squashed, not-yet-executed flag writers
- br_valid  in  1  branch requesting resolution
- br_ccc  in  3  branch condition code
- br_ready  out  1  branch may be accepted this cycle
- br_done  out  1  one-cycle pulse: a branch resolved last cycle
- br_taken  out  1  resolution result, valid while br_done=1
- z_flag, v_flag, n_flag  out  1 each  architectural flags
- pend_err  out  1  sticky counter over/underflow error

Behaviour:
Reset:
- rst=1 asynchronously clears z_flag, v_flag, n_flag, the pending count, br_done, br_taken and pend_err to 0.
- Reset mid-handshake discards the branch; no br_done follows.

Flag capture:
- zc = (alu_result == 16'h0000); vc = alu_v; nc = alu_n.
- On a clock edge with flag_wr_en=1, each flag whose flag_mask bit is 1 loads its captured value. Others hold.
- flag_wr_en=0 holds all flags.

Pending counter:
- next = pend + issue_fw − flag_wr_en − (flush ? flush_fw_cnt : 0), evaluated in one step, so a simultaneous inc/dec nets to 0.
- If the result is > DEPTH or < 0: set pend_err, then clamp to DEPTH or 0 respectively.
- flush does not cancel a same-cycle flag_wr_en; the executing op still commits.

Effective flags (combinational):
- Each of Ze/Ve/Ne = captured value if flag_wr_en and its mask bit are 1, else the register value.

Handshake:
- br_ready = (pend==0) | (pend==1 & flag_wr_en & ~issue_fw).
- Accept = br_valid & br_ready & ~flush. A branch arriving during flush is dropped.
- br_valid may stay high while br_ready=0; the requester must hold br_ccc stable.
- Latency is 1: the cycle after accept, br_done=1 and br_taken=cond(br_ccc, effective flags). Otherwise br_done=0 and br_taken holds its value.
- Back-to-back accepts give a continuous br_done.

Condition codes:
- 000 NEQ: ~Z
- 001 EQ: Z
- 010 GT: ~Z & ~N
- 011 LT: N
- 100 GTE: Z | (~Z & ~N)
- 101 LTE: N | Z
- 110 OVF: V
- 111 UNCOND: 1

State:
- Only the flag register, pending count, pend_err and the br_done/br_taken pipeline register.
- There is no FSM beyond the count. Count values 0..DEPTH act as the states: READY at 0, BYPASS-READY at 1, STALL above 1.

Decomposition:
- Shared package:
  - ccc constants CC_NEQ..CC_UNCOND
  - flag index constants FLAG_Z=2, FLAG_V=1, FLAG_N=0
  - mask constants FM_ALL=3'b111, FM_Z=3'b100
- One combinational sub-module, cond_eval(ccc, z, v, n, taken). It is reused by the branch predictor check.

Test Plan:
- Reset mid-operation: pend=2, flags=111, assert rst → all outputs 0 asynchronously; br_done stays 0.
- Capture and mask: flag_wr_en=1, mask=111, alu_result=0, v=1, n=0 → next cycle z,v,n=1,1,0. Then mask=100, alu_result=16'h0005, v=0, n=1 → z=0, v=1 and n=0 unchanged.
- Bypass branch: pend=1; in the same cycle flag_wr_en=1, mask=111, result=0, br_valid=1, ccc=001 → br_ready=1; next cycle br_done=1, br_taken=1, z_flag=1.
- Stall: issue_fw on 2 consecutive cycles, br_valid=1, ccc=011 → br_ready=0 until pend≤1 with flag_wr_en. Resolved with n=1 → br_taken=1, exactly one br_done pulse.
- Flush: pend=3, flush=1, flush_fw_cnt=2, flag_wr_en=1 → pend=0, flags updated; a same-cycle br_valid is not accepted.
- Error: pend=DEPTH plus issue_fw → pend_err=1 (sticky), pend stays 3. Sweep all 8 ccc × 8 flag combos against the truth table.

Source files
------------

// File: rtl/flag_cond_unit_pkg.sv
// Shared constants for the flag/condition unit: condition codes, flag bit
// positions inside the {Z,V,N} vector and the common flag write masks.
package flag_cond_unit_pkg;

  localparam int unsigned RES_W = 16;
  localparam int unsigned NFLAG = 3;

  localparam logic [2:0] CC_NEQ    = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVF    = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [2:0] FM_ALL = 3'b111;
  localparam logic [2:0] FM_Z   = 3'b100;

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Branch condition evaluator: maps a condition code and Z/V/N to taken.
// Purely combinational so the branch predictor check can share it.
module cond_eval
  import flag_cond_unit_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       z,
  input  logic       v,
  input  logic       n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (ccc)
      CC_NEQ:    taken = ~z;
      CC_EQ:     taken = z;
      CC_GT:     taken = ~z & ~n;
      CC_LT:     taken = n;
      CC_GTE:    taken = z | (~z & ~n);
      CC_LTE:    taken = n | z;
      CC_OVF:    taken = v;
      CC_UNCOND: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural flag register, in-flight flag-writer count and the
// branch resolution handshake with same-cycle bypass from EX.
module flag_cond_unit
  import flag_cond_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_fw,
  input  logic             flag_wr_en,
  input  logic [2:0]       flag_mask,
  input  logic [RES_W-1:0] alu_result,
  input  logic             alu_v,
  input  logic             alu_n,
  input  logic             flush,
  input  logic [CNT_W-1:0] flush_fw_cnt,
  input  logic             br_valid,
  input  logic [2:0]       br_ccc,
  output logic             br_ready,
  output logic             br_done,
  output logic             br_taken,
  output logic             z_flag,
  output logic             v_flag,
  output logic             n_flag,
  output logic             pend_err
);

  // Two guard bits cover both DEPTH+1 and the worst-case negative sum.
  localparam int unsigned SUM_W = CNT_W + 2;

  logic [NFLAG-1:0]        flags_q, flags_d, cap_flags, eff_flags;
  logic [CNT_W-1:0]        pend_q, pend_d;
  logic                    err_q, err_d;
  logic                    done_q, done_d;
  logic                    taken_q, taken_d;
  logic signed [SUM_W-1:0] pend_sum;
  logic                    accept;
  logic                    cond_taken;

  always_comb begin
    cap_flags         = '0;
    cap_flags[FLAG_Z] = (alu_result == '0);
    cap_flags[FLAG_V] = alu_v;
    cap_flags[FLAG_N] = alu_n;
    for (int i = 0; i < int'(NFLAG); i++) begin
      eff_flags[i] = (flag_wr_en & flag_mask[i]) ? cap_flags[i] : flags_q[i];
    end
    flags_d = eff_flags;
  end

  // Single-step net update so simultaneous issue/retire cancel before clamping.
  always_comb begin
    pend_sum = $signed(SUM_W'(pend_q)) + $signed(SUM_W'(issue_fw))
             - $signed(SUM_W'(flag_wr_en))
             - $signed(SUM_W'(flush ? flush_fw_cnt : '0));
    pend_d = '0;
    err_d  = err_q;
    if (pend_sum > $signed(SUM_W'(DEPTH))) begin
      pend_d = CNT_W'(DEPTH);
      err_d  = 1'b1;
    end else if (pend_sum < $signed(SUM_W'(0))) begin
      pend_d = '0;
      err_d  = 1'b1;
    end else begin
      pend_d = CNT_W'(pend_sum);
    end
  end

  assign br_ready = (pend_q == '0) |
                    ((pend_q == CNT_W'(1)) & flag_wr_en & ~issue_fw);
  assign accept   = br_valid & br_ready & ~flush;

  cond_eval u_cond_eval (
    .ccc   (br_ccc),
    .z     (eff_flags[FLAG_Z]),
    .v     (eff_flags[FLAG_V]),
    .n     (eff_flags[FLAG_N]),
    .taken (cond_taken)
  );

  always_comb begin
    done_d  = accept;
    taken_d = accept ? cond_taken : taken_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      done_q  <= done_d;
      taken_q <= taken_d;
    end
  end

  assign z_flag   = flags_q[FLAG_Z];
  assign v_flag   = flags_q[FLAG_V];
  assign n_flag   = flags_q[FLAG_N];
  assign pend_err = err_q;
  assign br_done  = done_q;
  assign br_taken = taken_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Bench for flag_cond_unit: vector table plus hand sequences, with a
// reference model and a queue of expected branch outcomes.
module tb_flag_cond_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_fw, flag_wr_en, alu_v, alu_n, flush, br_valid;
  logic [2:0]  flag_mask, br_ccc;
  logic [15:0] alu_result;
  logic [1:0]  flush_fw_cnt;
  logic        br_ready, br_done, br_taken, z_flag, v_flag, n_flag, pend_err;

  flag_cond_unit #(.DEPTH(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .issue_fw(issue_fw), .flag_wr_en(flag_wr_en),
    .flag_mask(flag_mask), .alu_result(alu_result), .alu_v(alu_v),
    .alu_n(alu_n), .flush(flush), .flush_fw_cnt(flush_fw_cnt),
    .br_valid(br_valid), .br_ccc(br_ccc), .br_ready(br_ready),
    .br_done(br_done), .br_taken(br_taken), .z_flag(z_flag),
    .v_flag(v_flag), .n_flag(n_flag), .pend_err(pend_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        issue, wr;
    logic [2:0]  mask;
    logic [15:0] res;
    logic        v, n, flush;
    logic [1:0]  fcnt;
    logic        bv;
    logic [2:0]  ccc;
    logic        exp_rdy;
    logic [2:0]  exp_zvn;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_pend  = 0;
  logic m_z = 0, m_v = 0, m_n = 0, m_err = 0, m_taken = 0;
  logic sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic issue, wr, input logic [2:0] mask,
                              input logic [15:0] res, input logic v, n, fl,
                              input logic [1:0] fcnt, input logic bv,
                              input logic [2:0] ccc, input logic rdy,
                              input logic [2:0] zvn);
    vec_t t;
    t.issue = issue; t.wr = wr; t.mask = mask; t.res = res; t.v = v; t.n = n;
    t.flush = fl; t.fcnt = fcnt; t.bv = bv; t.ccc = ccc;
    t.exp_rdy = rdy; t.exp_zvn = zvn;
    return t;
  endfunction

  function automatic logic cond_ref(input logic [2:0] c, input logic z, v, n);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle at posedge+1, check ready, then check registered outputs.
  task automatic run(input vec_t t, input bit use_exp);
    logic rdy, ze, ve, ne, exp_t;
    int   nxt;
    issue_fw = t.issue; flag_wr_en = t.wr; flag_mask = t.mask;
    alu_result = t.res; alu_v = t.v; alu_n = t.n; flush = t.flush;
    flush_fw_cnt = t.fcnt; br_valid = t.bv; br_ccc = t.ccc;
    #1;
    rdy = (m_pend == 0) || (m_pend == 1 && t.wr && !t.issue);
    chk("br_ready", br_ready, rdy);
    if (use_exp) chk("tbl_ready", br_ready, t.exp_rdy);
    ze = (t.wr && t.mask[2]) ? (t.res == 16'h0) : m_z;
    ve = (t.wr && t.mask[1]) ? t.v : m_v;
    ne = (t.wr && t.mask[0]) ? t.n : m_n;
    if (t.bv && rdy && !t.flush) sb.push_back(cond_ref(t.ccc, ze, ve, ne));
    nxt = m_pend + int'(t.issue) - int'(t.wr) - (t.flush ? int'(t.fcnt) : 0);
    if (nxt > 3) begin nxt = 3; m_err = 1'b1; end
    else if (nxt < 0) begin nxt = 0; m_err = 1'b1; end
    m_pend = nxt;
    m_z = ze; m_v = ve; m_n = ne;
    @(posedge clk);
    #1;
    chk("z_flag", z_flag, m_z);
    chk("v_flag", v_flag, m_v);
    chk("n_flag", n_flag, m_n);
    chk("pend_err", pend_err, m_err);
    if (use_exp) chk("tbl_zvn", {z_flag, v_flag, n_flag}, t.exp_zvn);
    if (sb.size() > 0) begin
      exp_t = sb.pop_front();
      chk("br_done", br_done, 1'b1);
      chk("br_taken", br_taken, exp_t);
      m_taken = exp_t;
    end else begin
      chk("br_done_idle", br_done, 1'b0);
      chk("br_taken_hold", br_taken, m_taken);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_z"}, z_flag, 1'b0);
    chk({tag, "_v"}, v_flag, 1'b0);
    chk({tag, "_n"}, n_flag, 1'b0);
    chk({tag, "_err"}, pend_err, 1'b0);
    chk({tag, "_done"}, br_done, 1'b0);
    chk({tag, "_taken"}, br_taken, 1'b0);
  endtask

  vec_t IDLE, ISSUE;

  initial begin
    IDLE  = mk(0, 0, 3'b000, 16'h1, 0, 0, 0, 2'd0, 0, 3'd0, 0, 3'b000);
    ISSUE = mk(1, 0, 3'b000, 16'h1, 0, 0, 0, 2'd0, 0, 3'd0, 0, 3'b000);
    run_init();

    // iss wr  mask    result   v  n  fl cnt bv ccc  rdy zvn
    tbl.push_back(mk(1, 0, 3'b000, 16'h0001, 0, 0, 0, 2'd0, 0, 3'd0, 1, 3'b000));
    tbl.push_back(mk(1, 1, 3'b111, 16'h0000, 1, 0, 0, 2'd0, 0, 3'd0, 0, 3'b110));
    tbl.push_back(mk(0, 1, 3'b100, 16'h0005, 0, 1, 0, 2'd0, 0, 3'd0, 1, 3'b010));
    tbl.push_back(mk(1, 0, 3'b000, 16'h0001, 0, 0, 0, 2'd0, 0, 3'd0, 1, 3'b010));
    tbl.push_back(mk(0, 1, 3'b111, 16'h0000, 0, 0, 0, 2'd0, 1, 3'd1, 1, 3'b100));
    tbl.push_back(mk(0, 0, 3'b000, 16'h0001, 0, 0, 0, 2'd0, 0, 3'd0, 1, 3'b100));
    tbl.push_back(mk(1, 0, 3'b000, 16'h0001, 0, 0, 0, 2'd0, 0, 3'd0, 1, 3'b100));
    tbl.push_back(mk(1, 0, 3'b000, 16'h0001, 0, 0, 0, 2'd0, 0, 3'd0, 0, 3'b100));
    tbl.push_back(mk(0, 0, 3'b000, 16'h0001, 0, 0, 0, 2'd0, 1, 3'd3, 0, 3'b100));
    tbl.push_back(mk(0, 1, 3'b111, 16'h0001, 0, 1, 0, 2'd0, 1, 3'd3, 0, 3'b001));
    tbl.push_back(mk(0, 1, 3'b100, 16'h0003, 0, 0, 0, 2'd0, 1, 3'd3, 1, 3'b001));
    tbl.push_back(mk(0, 0, 3'b000, 16'h0001, 0, 0, 0, 2'd0, 0, 3'd0, 1, 3'b001));
    tbl.push_back(mk(0, 0, 3'b000, 16'h0001, 0, 0, 0, 2'd0, 0, 3'd0, 1, 3'b001));
    foreach (tbl[i]) run(tbl[i], 1'b1);

    // Flush of two squashed writers with a committing op; branch dropped.
    repeat (3) run(ISSUE, 1'b0);
    run(mk(0, 1, 3'b111, 16'h0000, 1, 1, 1, 2'd2, 1, 3'd7, 0, 3'b000), 1'b0);
    run(mk(0, 0, 3'b000, 16'h0001, 0, 0, 1, 2'd0, 1, 3'd7, 0, 3'b000), 1'b0);
    run(IDLE, 1'b0);

    // Every condition code against every flag combination via bypass.
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic [15:0] r;
        logic [2:0]  fb;
        fb = 3'(f);
        r  = fb[2] ? 16'h0000 : 16'($urandom_range(1, 65535));
        run(ISSUE, 1'b0);
        run(mk(0, 1, 3'b111, r, fb[1], fb[0], 0, 2'd0, 1, 3'(c), 0, 3'b000), 1'b0);
      end
    end
    run(IDLE, 1'b0);

    // Overflow clamps at DEPTH, then underflow clamps at zero; error sticks.
    repeat (4) run(ISSUE, 1'b0);
    repeat (2) run(mk(0, 1, 3'b111, 16'h0001, 0, 0, 0, 2'd0, 0, 3'd0, 0, 3'b000), 1'b0);
    run(mk(0, 1, 3'b111, 16'h0000, 0, 0, 0, 2'd0, 1, 3'd7, 0, 3'b000), 1'b0);
    run(mk(0, 1, 3'b111, 16'h8000, 1, 1, 0, 2'd0, 0, 3'd0, 0, 3'b000), 1'b0);
    run(IDLE, 1'b0);

    // Mid-operation asynchronous reset with pend=2 and flags 111.
    repeat (3) run(ISSUE, 1'b0);
    run(mk(0, 1, 3'b111, 16'h0000, 1, 1, 0, 2'd0, 0, 3'd0, 0, 3'b000), 1'b0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    m_pend = 0; m_z = 0; m_v = 0; m_n = 0; m_err = 0; m_taken = 0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run(IDLE, 1'b0);

    // Reset landing on an accepted handshake discards the branch.
    issue_fw = 0; flag_wr_en = 0; flush = 0; br_valid = 1; br_ccc = 3'd7;
    #1 chk("hs_ready", br_ready, 1'b1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    br_valid = 0;
    chk("hs_rst_done", br_done, 1'b0);
    rst = 1'b0;
    run(IDLE, 1'b0);
    run(IDLE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic run_init();
    issue_fw = 0; flag_wr_en = 0; flag_mask = 0; alu_result = 0; alu_v = 0;
    alu_n = 0; flush = 0; flush_fw_cnt = 0; br_valid = 0; br_ccc = 0;
    #1 rst = 1'b1;
    #2 chk_reset_outputs("init_rst");
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

endmodule
